pb_scan_controller: RTL and testbench

//  Multi-button debounce scheduler for the front-panel/controller inputs. A single shared

---
 rtl/pb_scan_controller.sv | 146 ++++++++++++++
 tb/tb_pb_scan_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pb_scan_controller.sv
// Multi-button debounce scheduler: one shared prescaler visits each button in turn,
// per-button stability counters filter bounce, and events leave round-robin on a valid/ready stream.
module pb_scan_controller #(
  parameter int N_BTN          = 4,
  parameter int SCAN_DIV       = 1024,
  parameter int STABLE_SAMPLES = 16,
  localparam int IDW           = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pb_n_in,
  output logic [N_BTN-1:0] pb_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_press,
  output logic             evt_overrun
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(STABLE_SAMPLES);

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [PW-1:0]    psc_q, psc_d;
  logic [IDW-1:0]   slot_q, slot_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] state_q, state_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] pdir_q, pdir_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             press_q, press_d;
  logic             ovr_q, ovr_d;

  logic           tick;
  logic           chg;
  logic           load;
  logic           found;
  logic [IDW-1:0] sel;
  int             idx;

  always_comb begin
    tick   = (psc_q == PW'(SCAN_DIV - 1));
    psc_d  = tick ? '0 : psc_q + PW'(1);
    slot_d = slot_q;
    if (tick) begin
      slot_d = (slot_q == IDW'(N_BTN - 1)) ? '0 : slot_q + IDW'(1);
    end

    // Only the button owning the current scan slot is sampled on a tick.
    cnt_d   = cnt_q;
    state_d = state_q;
    pdir_d  = pdir_q;
    chg     = 1'b0;
    if (tick) begin
      if (s2_q[slot_q] == state_q[slot_q]) begin
        cnt_d[slot_q] = '0;
      end else if (cnt_q[slot_q] == CW'(STABLE_SAMPLES - 1)) begin
        state_d[slot_q] = ~state_q[slot_q];
        pdir_d[slot_q]  = ~state_q[slot_q];
        cnt_d[slot_q]   = '0;
        chg             = 1'b1;
      end else begin
        cnt_d[slot_q] = cnt_q[slot_q] + CW'(1);
      end
    end

    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_BTN; i++) begin
      idx = (int'(rr_q) + i) % N_BTN;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end

    load    = !valid_q || evt_ready;
    pend_d  = pend_q;
    valid_d = valid_q;
    id_d    = id_q;
    press_d = press_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        id_d        = sel;
        press_d     = pdir_q[sel];
        pend_d[sel] = 1'b0;
        rr_d        = (sel == IDW'(N_BTN - 1)) ? '0 : sel + IDW'(1);
      end
    end

    // A same-cycle grant of this bit consumes the old direction, so re-setting it is not a loss.
    ovr_d = chg && pend_q[slot_q] && !(load && found && (sel == slot_q));
    if (chg) begin
      pend_d[slot_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      psc_q   <= '0;
      slot_q  <= '0;
      rr_q    <= '0;
      state_q <= '0;
      pend_q  <= '0;
      pdir_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      press_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int b = 0; b < N_BTN; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      s1_q    <= ~pb_n_in;
      s2_q    <= s1_q;
      psc_q   <= psc_d;
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      press_q <= press_d;
      ovr_q   <= ovr_d;
      for (int b = 0; b < N_BTN; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign pb_state    = state_q;
  assign evt_valid   = valid_q;
  assign evt_id      = id_q;
  assign evt_press   = press_q;
  assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_pb_scan_controller.sv
// Directed bench for pb_scan_controller with N_BTN=4, SCAN_DIV=4, STABLE_SAMPLES=3
// (each button sampled every 16 clocks, three disagreeing samples change its state).
module tb_pb_scan_controller;

  logic       clk;
  logic       rst;
  logic [3:0] pb_n_in;
  logic [3:0] pb_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       evt_overrun;

  int checkCount;
  int passCount;
  int failCount;
  int ovrCount;
  int validCycles;
  int used;

  logic [1:0] idQ[$];
  logic       pressQ[$];

  pb_scan_controller #(
    .N_BTN(4),
    .SCAN_DIV(4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb_n_in(pb_n_in),
    .pb_state(pb_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_press(evt_press),
    .evt_overrun(evt_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so the falling edge sees settled handshakes.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      idQ.push_back(evt_id);
      pressQ.push_back(evt_press);
    end
    if (!rst && evt_overrun) ovrCount++;
    if (!rst && evt_valid) validCycles++;
  end

  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pbN, input logic ready);
    pb_n_in   = pbN;
    evt_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Leaves the bench 1ns after the last reset edge, which is cycle zero of the scan schedule.
  task automatic doReset(input int n);
    rst = 1'b1;
    stepClk(n);
    rst = 1'b0;
    idQ.delete();
    pressQ.delete();
    ovrCount    = 0;
    validCycles = 0;
  endtask

  task automatic waitBtn(input int b, input logic v, input int limit, output int cycles);
    cycles = 0;
    while (pb_state[b] !== v && cycles <= limit) begin
      stepClk(1);
      cycles++;
    end
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    failCount   = 0;
    ovrCount    = 0;
    validCycles = 0;
    rst         = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    stepClk(1);

    $display("[TB] test 1: idle after reset");
    doReset(2);
    checkOutput("rst_pb_state", pb_state, 0);
    checkOutput("rst_evt_valid", evt_valid, 0);
    checkOutput("rst_evt_id", evt_id, 0);
    checkOutput("rst_evt_press", evt_press, 0);
    checkOutput("rst_evt_overrun", evt_overrun, 0);
    stepClk(500);
    checkOutput("t1_valid_cycles", validCycles, 0);
    checkOutput("t1_pb_state", pb_state, 0);

    $display("[TB] test 2: single press and release of btn2");
    doReset(2);
    applyStimulus(4'b1011, 1'b1);
    waitBtn(2, 1'b1, 70, used);
    checkOutput("t2_press_latency_ok", used <= 64, 1);
    stepClk(4);
    checkOutput("t2_press_evt_count", idQ.size(), 1);
    checkOutput("t2_press_evt_id", idQ[0], 2);
    checkOutput("t2_press_evt_dir", pressQ[0], 1);
    applyStimulus(4'b1111, 1'b1);
    waitBtn(2, 1'b0, 70, used);
    checkOutput("t2_release_latency_ok", used <= 64, 1);
    stepClk(4);
    checkOutput("t2_release_evt_count", idQ.size(), 2);
    checkOutput("t2_release_evt_id", idQ[1], 2);
    checkOutput("t2_release_evt_dir", pressQ[1], 0);
    checkOutput("t2_valid_idle", evt_valid, 0);

    $display("[TB] test 3: bouncing btn1");
    doReset(2);
    applyStimulus(4'b1111, 1'b1);
    stepClk(3);
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b1101 : 4'b1111, 1'b1);
      stepClk(10);
    end
    checkOutput("t3_bounce_state", pb_state, 0);
    checkOutput("t3_bounce_evt_count", idQ.size(), 0);
    applyStimulus(4'b1101, 1'b1);
    waitBtn(1, 1'b1, 70, used);
    checkOutput("t3_settle_latency_ok", used <= 64, 1);
    stepClk(4);
    checkOutput("t3_evt_count", idQ.size(), 1);
    checkOutput("t3_evt_id", idQ[0], 1);
    checkOutput("t3_evt_dir", pressQ[0], 1);

    $display("[TB] test 4: btn0 and btn3 together with backpressure");
    doReset(2);
    applyStimulus(4'b0110, 1'b0);
    stepClk(37);
    checkOutput("t4_first_valid", evt_valid, 1);
    checkOutput("t4_first_id", evt_id, 0);
    checkOutput("t4_first_press", evt_press, 1);
    stepClk(13);
    checkOutput("t4_held_valid", evt_valid, 1);
    checkOutput("t4_held_id", evt_id, 0);
    checkOutput("t4_held_press", evt_press, 1);
    checkOutput("t4_pb_state", pb_state, 4'b1001);
    applyStimulus(4'b0110, 1'b1);
    stepClk(2);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("t4_drained_valid", evt_valid, 0);
    checkOutput("t4_evt_count", idQ.size(), 2);
    checkOutput("t4_evt0_id", idQ[0], 0);
    checkOutput("t4_evt1_id", idQ[1], 3);
    checkOutput("t4_evt1_dir", pressQ[1], 1);
    checkOutput("t4_no_overrun", ovrCount, 0);

    $display("[TB] test 5: overrun of btn0 behind a held btn1 event");
    doReset(2);
    applyStimulus(4'b1101, 1'b0);
    stepClk(41);
    checkOutput("t5_held_valid", evt_valid, 1);
    checkOutput("t5_held_id", evt_id, 1);
    applyStimulus(4'b1100, 1'b0);
    waitBtn(0, 1'b1, 100, used);
    checkOutput("t5_press_seen", used <= 100, 1);
    checkOutput("t5_no_overrun_yet", ovrCount, 0);
    applyStimulus(4'b1101, 1'b0);
    waitBtn(0, 1'b0, 100, used);
    checkOutput("t5_release_seen", used <= 100, 1);
    stepClk(2);
    checkOutput("t5_overrun_pulses", ovrCount, 1);
    checkOutput("t5_still_id", evt_id, 1);
    checkOutput("t5_still_press", evt_press, 1);
    applyStimulus(4'b1101, 1'b1);
    stepClk(2);
    applyStimulus(4'b1101, 1'b0);
    checkOutput("t5_evt_count", idQ.size(), 2);
    checkOutput("t5_evt0_id", idQ[0], 1);
    checkOutput("t5_evt1_id", idQ[1], 0);
    checkOutput("t5_evt1_dir", pressQ[1], 0);
    checkOutput("t5_valid_idle", evt_valid, 0);

    $display("[TB] test 6: reset mid-handshake and mid-count");
    doReset(2);
    applyStimulus(4'b1001, 1'b0);
    stepClk(41);
    checkOutput("t6_pre_valid", evt_valid, 1);
    checkOutput("t6_pre_state", pb_state, 4'b0010);
    rst = 1'b1;
    stepClk(1);
    rst = 1'b0;
    checkOutput("t6_rst_pb_state", pb_state, 0);
    checkOutput("t6_rst_valid", evt_valid, 0);
    checkOutput("t6_rst_id", evt_id, 0);
    checkOutput("t6_rst_press", evt_press, 0);
    checkOutput("t6_rst_overrun", evt_overrun, 0);
    stepClk(43);
    checkOutput("t6_btn2_not_yet", pb_state[2], 0);
    stepClk(1);
    checkOutput("t6_btn2_redebounced", pb_state[2], 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
